// File: rtl/wm_prng_gen.sv
// Watermark symbol generator: a keyed Fibonacci-style LFSR stepped once per
// accepted symbol, framed into FRAME_LEN-symbol runs by an IDLE/RUN/DONE FSM.
module wm_prng_gen #(
    parameter int                LFSR_W    = 8,
    parameter logic [LFSR_W-1:0] TAPS      = 8'h8E,
    parameter logic [LFSR_W-1:0] SEED      = 8'h6A,
    parameter int                SYM_W     = 2,
    parameter int                FRAME_LEN = 1024,
    localparam int               CNT_W     = $clog2(FRAME_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_in,
    input  logic              wm_mode,
    input  logic              out_ready,
    output logic              wm_valid,
    output logic [SYM_W-1:0]  wm_data,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  sym_count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

    state_t            state_reg;
    state_t            state_next;
    logic [LFSR_W-1:0] key_reg;
    logic [LFSR_W-1:0] lfsr_reg;
    logic [LFSR_W-1:0] lfsr_next;
    logic [LFSR_W-1:0] load_key;
    logic [LFSR_W-1:0] frame_key;
    logic [CNT_W-1:0]  sym_count_reg;
    logic              mode_reg;
    logic              in_idle;
    logic              in_run;
    logic              accept;
    logic              last_accept;
    logic              feedback;

    assign in_idle     = (state_reg == ST_IDLE);
    assign in_run      = (state_reg == ST_RUN);
    assign accept      = in_run & out_ready;
    assign last_accept = accept & (sym_count_reg == CNT_LAST);

    // An all-zero key would lock the LFSR, so it is replaced by SEED.
    assign load_key  = (seed_in == '0) ? SEED : seed_in;
    // A seed_load in the same cycle as start must already seed this frame.
    assign frame_key = (in_idle & seed_load) ? load_key : key_reg;

    assign feedback  = ^(lfsr_reg & TAPS);
    assign lfsr_next = {lfsr_reg[LFSR_W-2:0], feedback};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start) state_next = ST_RUN;
            ST_RUN:  if (last_accept) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_reg       <= SEED;
            lfsr_reg      <= SEED;
            sym_count_reg <= '0;
            mode_reg      <= 1'b0;
        end else begin
            if (in_idle && seed_load) begin
                key_reg <= load_key;
            end
            if (in_idle && start) begin
                lfsr_reg      <= frame_key;
                sym_count_reg <= '0;
                mode_reg      <= wm_mode;
            end else if (accept) begin
                lfsr_reg      <= lfsr_next;
                sym_count_reg <= sym_count_reg + CNT_W'(1);
            end
        end
    end

    // Symbol bit 0 is the raw LFSR output; higher bits are adjacent-bit XORs
    // in full mode and forced to zero in single-bit mode.
    assign wm_data[0] = in_run & lfsr_reg[0];

    generate
        for (genvar gi = 1; gi < SYM_W; gi++) begin : g_sym_bit
            assign wm_data[gi] = in_run & mode_reg & (lfsr_reg[gi] ^ lfsr_reg[gi-1]);
        end
    endgenerate

    assign wm_valid  = in_run;
    assign busy      = in_run;
    assign done      = (state_reg == ST_DONE);
    assign sym_count = sym_count_reg;

endmodule

// File: tb/tb_wm_prng_gen.sv
// Randomized bench for wm_prng_gen against an arithmetic reference model of
// the keyed LFSR symbol stream, with stalls, ignored controls and aborts.
module tb_wm_prng_gen;

    localparam int LFSR_W    = 8;
    localparam int SYM_W     = 2;
    localparam int FRAME_LEN = 1024;
    localparam int CNT_W     = $clog2(FRAME_LEN + 1);
    localparam int TAPS_I    = 'h8E;
    localparam int SEED_I    = 'h6A;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              seed_load = 1'b0;
    logic [LFSR_W-1:0] seed_in = '0;
    logic              wm_mode = 1'b0;
    logic              out_ready = 1'b0;
    logic              wm_valid;
    logic [SYM_W-1:0]  wm_data;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  sym_count;

    int n_cmp = 0;
    int n_bad = 0;
    int key_m = SEED_I;

    wm_prng_gen #(
        .LFSR_W   (LFSR_W),
        .TAPS     (8'h8E),
        .SEED     (8'h6A),
        .SYM_W    (SYM_W),
        .FRAME_LEN(FRAME_LEN)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .seed_load(seed_load),
        .seed_in  (seed_in),
        .wm_mode  (wm_mode),
        .out_ready(out_ready),
        .wm_valid (wm_valid),
        .wm_data  (wm_data),
        .busy     (busy),
        .done     (done),
        .sym_count(sym_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: shift left within 8 bits, feed in parity of the tapped bits.
    function automatic int model_step(input int s);
        return ((s * 2) % 256) + ($countones(s & TAPS_I) % 2);
    endfunction

    function automatic int model_sym(input int s, input int mode);
        if (mode != 0) return (s ^ (s * 2)) % 4;
        return s % 2;
    endfunction

    function automatic int model_key(input int v);
        return (v == 0) ? SEED_I : v;
    endfunction

    task automatic check_idle(input string tag, input int cnt_exp);
        check({tag, "_valid"}, int'(wm_valid), 0);
        check({tag, "_busy"},  int'(busy), 0);
        check({tag, "_done"},  int'(done), 0);
        check({tag, "_data"},  int'(wm_data), 0);
        check({tag, "_cnt"},   int'(sym_count), cnt_exp);
    endtask

    task automatic idle_load(input int v);
        seed_load = 1'b1;
        seed_in   = LFSR_W'(v);
        @(negedge clk);
        seed_load = 1'b0;
        key_m     = model_key(v);
        $display("load seed_in=%02h key=%02h", v, key_m);
    endtask

    // Runs one whole frame; called at a negedge with the DUT in IDLE.
    task automatic run_frame(input string name, input int mode, input int ready_pct,
                             input bit load_at_start, input int load_val);
        int s, cnt, cyc, prev_ready, prev_data, first_sym;
        start   = 1'b1;
        wm_mode = mode[0];
        if (load_at_start) begin
            seed_load = 1'b1;
            seed_in   = LFSR_W'(load_val);
            key_m     = model_key(load_val);
        end
        @(negedge clk);
        start     = 1'b0;
        seed_load = 1'b0;
        s = key_m;
        first_sym = model_sym(s, mode);
        cnt = 0; cyc = 0; prev_ready = 1; prev_data = 0;
        check({name, "_valid_lat"}, int'(wm_valid), 1);
        while (cnt < FRAME_LEN && cyc < 20000) begin
            check({name, "_valid"}, int'(wm_valid), 1);
            check({name, "_busy"},  int'(busy), 1);
            check({name, "_done"},  int'(done), 0);
            check({name, "_cnt"},   int'(sym_count), cnt);
            check({name, "_data"},  int'(wm_data), model_sym(s, mode));
            if (mode == 0) check({name, "_msb0"}, int'(wm_data[1]), 0);
            if (prev_ready == 0) check({name, "_stall"}, int'(wm_data), prev_data);
            prev_data = int'(wm_data);
            out_ready = ($urandom_range(99) < ready_pct);
            prev_ready = int'(out_ready);
            wm_mode   = 1'($urandom);
            start     = ($urandom_range(9) == 0);
            seed_load = ($urandom_range(9) == 0);
            seed_in   = LFSR_W'($urandom);
            @(negedge clk);
            if (prev_ready != 0) begin
                s = model_step(s);
                cnt++;
            end
            cyc++;
        end
        check({name, "_timeout"}, cnt, FRAME_LEN);
        // DONE cycle: start and seed_load here must be dropped.
        start = 1'b1; seed_load = 1'b1; seed_in = LFSR_W'($urandom); out_ready = 1'b0;
        check({name, "_done_pulse"}, int'(done), 1);
        check({name, "_done_busy"},  int'(busy), 0);
        check({name, "_done_valid"}, int'(wm_valid), 0);
        check({name, "_done_cnt"},   int'(sym_count), FRAME_LEN);
        @(negedge clk);
        start = 1'b0; seed_load = 1'b0;
        check_idle({name, "_idle1"}, FRAME_LEN);
        @(negedge clk);
        check_idle({name, "_idle2"}, FRAME_LEN);
        $display("frame %s mode=%0d key=%02h first_sym=%0d cycles=%0d accepted=%0d",
                 name, mode, key_m, first_sym, cyc, cnt);
    endtask

    task automatic run_abort();
        int s;
        start = 1'b1; wm_mode = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        s = key_m;
        for (int i = 0; i < 10; i++) begin
            check("abort_data", int'(wm_data), model_sym(s, 1));
            @(negedge clk);
            s = model_step(s);
        end
        check("abort_cnt", int'(sym_count), 10);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b0;
        key_m = SEED_I;
        check_idle("abort_rst", 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_nodone", int'(done), 0);
            check("abort_nobusy", int'(busy), 0);
        end
        $display("abort after 10 symbols, key=%02h", key_m);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_idle("reset", 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("post_reset", 0);
        $display("reset checked");

        // First two full-mode symbols from the default key are fixed: 2, 0.
        start = 1'b1; wm_mode = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("first_valid", int'(wm_valid), 1);
        check("first_sym", int'(wm_data), 2);
        @(negedge clk);
        check("second_sym", int'(wm_data), 0);
        out_ready = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        $display("first symbols checked");

        run_frame("m1_full", 1, 100, 1'b0, 0);
        run_frame("m0_full", 0, 100, 1'b0, 0);
        idle_load(0);
        run_frame("zero_seed", 1, 60, 1'b0, 0);
        run_frame("load_01", $urandom_range(1), 50, 1'b1, 1);
        run_frame("keep_01", 1, 70, 1'b0, 0);
        run_abort();
        run_frame("replay", 1, 100, 1'b0, 0);
        for (int f = 0; f < 4; f++) begin
            int v;
            v = ($urandom_range(3) == 0) ? 0 : $urandom_range(255);
            idle_load(v);
            run_frame("rand", $urandom_range(1), $urandom_range(40, 90), 1'b0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
